// File: rtl/trig_arb_pkg.sv
// rtl/trig_arb_pkg.sv - shared types and constants for the trigger round-robin arbiter
package trig_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    // Edge detection stays masked until the synchronizer holds real samples
    localparam int WARM_LEN = 3;

endpackage

// File: rtl/trig_rr_arbiter_if.sv
// rtl/trig_rr_arbiter_if.sv - valid/ready grant port between arbiter and event consumer
interface trig_rr_arbiter_if #(
    parameter int ID_W = 2
);
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic            grant_ready;

    modport master (output grant_valid, output grant_id, input grant_ready);
    modport slave  (input grant_valid, input grant_id, output grant_ready);
endinterface

// File: rtl/sync_2stage.sv
// rtl/sync_2stage.sv - two-flop synchronizer bank; no reset so the flops stay plain
module sync_2stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        meta_q <= d_i;
        sync_q <= meta_q;
    end

    assign q_o = sync_q;
endmodule

// File: rtl/trig_rr_arbiter.sv
// rtl/trig_rr_arbiter.sv - latches async trigger edges and grants them round-robin
module trig_rr_arbiter
    import trig_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DROP_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_async,
    input  logic [N_REQ-1:0]   chan_en,
    trig_rr_arbiter_if.master  grant,
    output logic [N_REQ-1:0]   pending,
    output logic [N_REQ-1:0]   overflow,
    output logic [DROP_W-1:0]  drop_cnt,
    input  logic               clear_stats
);
    logic [N_REQ-1:0]  sync_out;
    logic [N_REQ-1:0]  prev_q;
    logic [1:0]        warm_q, warm_d;
    logic              warm;
    logic [N_REQ-1:0]  edge_det, serve, drop;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_W:0]   cnt_sum;
    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rr_q, rr_d;

    sync_2stage #(.WIDTH(N_REQ)) u_sync (
        .clk (clk),
        .d_i (req_async),
        .q_o (sync_out)
    );

    // First pending channel at or after ptr, wrapping around
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        return pick;
    endfunction

    assign warm   = (warm_q == 2'(WARM_LEN));
    assign warm_d = warm ? warm_q : warm_q + 2'd1;

    always_comb begin
        edge_det = sync_out & ~prev_q & chan_en & {N_REQ{warm}};
        serve    = '0;
        if (state_q == OFFER && grant.grant_ready) begin
            serve[grant_id_q] = 1'b1;
        end
        drop      = edge_det & pending_q & ~serve;
        pending_d = ((pending_q & ~serve) | edge_det) & chan_en;
    end

    always_comb begin
        cnt_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < N_REQ; i++) begin
            if (drop[i]) begin
                cnt_sum = cnt_sum + (DROP_W+1)'(1);
            end
        end
        if (clear_stats) begin
            drop_cnt_d = '0;
            overflow_d = '0;
        end else begin
            drop_cnt_d = cnt_sum[DROP_W] ? '1 : cnt_sum[DROP_W-1:0];
            overflow_d = overflow_q | drop;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_d       = rr_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_id_d = rr_pick(pending_q, rr_q);
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (grant.grant_ready) begin
                    state_d = IDLE;
                    rr_d    = (grant_id_q == ID_W'(N_REQ-1)) ? '0 : grant_id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '1;
            warm_q     <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
            drop_cnt_q <= '0;
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_q       <= '0;
        end else begin
            prev_q     <= sync_out;
            warm_q     <= warm_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_q       <= rr_d;
        end
    end

    assign grant.grant_valid = (state_q == OFFER);
    assign grant.grant_id    = grant_id_q;
    assign pending           = pending_q;
    assign overflow          = overflow_q;
    assign drop_cnt          = drop_cnt_q;
endmodule
